// File: rtl/parking_zone_manager.sv
// ----------------------------------------------------------------------------
// parking_zone_manager
//
// Tracks occupancy of NUM_ZONES independent parking zones. Each zone has an
// entry and an exit sensor. A rising edge on a sensor is one car event. Entry
// events open that zone's gate for GATE_HOLD cycles, or are refused with a
// one-cycle Reject pulse when the zone is full.
//
// Optional feature macro: PARKING_ERR_FLAG_EN
//   defined   : ERR is a sticky flag. It is set by any Reject or by an exit
//               event ignored at count 0, and cleared only by RESET.
//   undefined : ERR is tied to 0 and no error logic is built.
//
// Ports
//   CLK              in   clock, rising-edge active
//   RESET            in   synchronous, active-high reset
//   ENTRY_sensor     in   [NUM_ZONES]        per-zone entry sensor level
//   EXIT_sensor      in   [NUM_ZONES]        per-zone exit sensor level
//   Parking_count    out  [NUM_ZONES*CNT_W]  occupied count, zone z at [z*CNT_W +: CNT_W]
//   Available_spots  out  [NUM_ZONES*CNT_W]  ZONE_CAP minus count, same packing
//   Total_count      out  [8]                sum of all zone counts
//   FULL / EMPTY     out  [NUM_ZONES]        count==ZONE_CAP / count==0
//   ALL_FULL         out  1                  every zone full
//   GATE_open        out  [NUM_ZONES]        per-zone entry gate drive
//   Reject           out  [NUM_ZONES]        one-cycle refusal pulse
//   ERR              out  1                  sticky error flag (see macro)
// ----------------------------------------------------------------------------
module parking_zone_manager #(
    parameter int NUM_ZONES = 2,
    parameter int ZONE_CAP  = 8,
    parameter int CNT_W     = 4,
    parameter int GATE_HOLD = 3
) (
    input  logic                       CLK,
    input  logic                       RESET,
    input  logic [NUM_ZONES-1:0]       ENTRY_sensor,
    input  logic [NUM_ZONES-1:0]       EXIT_sensor,
    output logic [NUM_ZONES*CNT_W-1:0] Parking_count,
    output logic [NUM_ZONES*CNT_W-1:0] Available_spots,
    output logic [7:0]                 Total_count,
    output logic [NUM_ZONES-1:0]       FULL,
    output logic [NUM_ZONES-1:0]       EMPTY,
    output logic                       ALL_FULL,
    output logic [NUM_ZONES-1:0]       GATE_open,
    output logic [NUM_ZONES-1:0]       Reject,
    output logic                       ERR
);

    // Timer holds the remaining open cycles minus one, so GATE_HOLD-1 max.
    localparam int HOLD_W = (GATE_HOLD > 1) ? $clog2(GATE_HOLD) : 1;

    typedef enum logic {
        GATE_CLOSED = 1'b0,
        GATE_OPEN   = 1'b1
    } gate_state_e;

    // Edge detection
    logic [NUM_ZONES-1:0] entry_prev_q, exit_prev_q;
    logic [NUM_ZONES-1:0] entry_edge, exit_edge;

    assign entry_edge = ENTRY_sensor & ~entry_prev_q;
    assign exit_edge  = EXIT_sensor  & ~exit_prev_q;

    // Occupancy datapath
    logic [CNT_W-1:0]             count_q [NUM_ZONES];
    logic [CNT_W-1:0]             count_d [NUM_ZONES];
    logic [NUM_ZONES-1:0]         grant;
    logic [NUM_ZONES-1:0]         reject_d, reject_q;
    logic [NUM_ZONES-1:0]         full_d, full_q;
    logic [NUM_ZONES-1:0]         empty_d, empty_q;
    logic                         all_full_d, all_full_q;
    logic [7:0]                   total_d, total_q;
    logic [NUM_ZONES*CNT_W-1:0]   avail_d, avail_q;

    // Gate FSM
    gate_state_e                  gate_q  [NUM_ZONES];
    gate_state_e                  gate_d  [NUM_ZONES];
    logic [HOLD_W-1:0]            timer_q [NUM_ZONES];
    logic [HOLD_W-1:0]            timer_d [NUM_ZONES];

    // Count update and derived status. Status outputs are computed from the
    // next count so they are registered on the same edge as the count itself.
    always_comb begin
        grant      = '0;
        reject_d   = '0;
        full_d     = '0;
        empty_d    = '0;
        avail_d    = '0;
        total_d    = '0;
        for (int unsigned z = 0; z < NUM_ZONES; z++) begin
            count_d[z] = count_q[z];
            if (entry_edge[z] && exit_edge[z]) begin
                // A car leaving frees the spot the arriving car takes.
                grant[z] = 1'b1;
            end else if (entry_edge[z]) begin
                if (count_q[z] == CNT_W'(ZONE_CAP)) begin
                    reject_d[z] = 1'b1;
                end else begin
                    count_d[z] = count_q[z] + CNT_W'(1);
                    grant[z]   = 1'b1;
                end
            end else if (exit_edge[z]) begin
                if (count_q[z] != '0) begin
                    count_d[z] = count_q[z] - CNT_W'(1);
                end
            end
            full_d[z]                   = (count_d[z] == CNT_W'(ZONE_CAP));
            empty_d[z]                  = (count_d[z] == '0);
            avail_d[z*CNT_W +: CNT_W]   = CNT_W'(ZONE_CAP) - count_d[z];
            total_d                     = total_d + 8'(count_d[z]);
        end
        all_full_d = &full_d;
    end

    // Gate next-state: a grant (re)loads the hold timer in either state.
    always_comb begin
        for (int unsigned z = 0; z < NUM_ZONES; z++) begin
            gate_d[z]  = gate_q[z];
            timer_d[z] = timer_q[z];
            case (gate_q[z])
                GATE_CLOSED: begin
                    if (grant[z]) begin
                        gate_d[z]  = GATE_OPEN;
                        timer_d[z] = HOLD_W'(GATE_HOLD - 1);
                    end
                end
                GATE_OPEN: begin
                    if (grant[z]) begin
                        timer_d[z] = HOLD_W'(GATE_HOLD - 1);
                    end else if (timer_q[z] == '0) begin
                        gate_d[z] = GATE_CLOSED;
                    end else begin
                        timer_d[z] = timer_q[z] - HOLD_W'(1);
                    end
                end
                default: gate_d[z] = GATE_CLOSED;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            entry_prev_q <= '0;
            exit_prev_q  <= '0;
            reject_q     <= '0;
            full_q       <= '0;
            empty_q      <= '1;
            all_full_q   <= 1'b0;
            total_q      <= '0;
            for (int unsigned z = 0; z < NUM_ZONES; z++) begin
                count_q[z]                <= '0;
                gate_q[z]                 <= GATE_CLOSED;
                timer_q[z]                <= '0;
                avail_q[z*CNT_W +: CNT_W] <= CNT_W'(ZONE_CAP);
            end
        end else begin
            entry_prev_q <= ENTRY_sensor;
            exit_prev_q  <= EXIT_sensor;
            reject_q     <= reject_d;
            full_q       <= full_d;
            empty_q      <= empty_d;
            all_full_q   <= all_full_d;
            total_q      <= total_d;
            avail_q      <= avail_d;
            for (int unsigned z = 0; z < NUM_ZONES; z++) begin
                count_q[z] <= count_d[z];
                gate_q[z]  <= gate_d[z];
                timer_q[z] <= timer_d[z];
            end
        end
    end

    always_comb begin
        Parking_count = '0;
        GATE_open     = '0;
        for (int unsigned z = 0; z < NUM_ZONES; z++) begin
            Parking_count[z*CNT_W +: CNT_W] = count_q[z];
            GATE_open[z]                    = (gate_q[z] == GATE_OPEN);
        end
    end

    assign Available_spots = avail_q;
    assign Total_count     = total_q;
    assign FULL            = full_q;
    assign EMPTY           = empty_q;
    assign ALL_FULL        = all_full_q;
    assign Reject          = reject_q;

`ifdef PARKING_ERR_FLAG_EN
    logic [NUM_ZONES-1:0] ignored_exit;
    logic                 err_q;

    // An exit paired with an entry in the same cycle is not an ignored exit.
    always_comb begin
        ignored_exit = '0;
        for (int unsigned z = 0; z < NUM_ZONES; z++) begin
            ignored_exit[z] = exit_edge[z] && !entry_edge[z] && (count_q[z] == '0);
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            err_q <= 1'b0;
        end else if ((|reject_d) || (|ignored_exit)) begin
            err_q <= 1'b1;
        end
    end

    assign ERR = err_q;
`else
    assign ERR = 1'b0;
`endif

endmodule

// File: tb/tb_parking_zone_manager.sv
// ----------------------------------------------------------------------------
// tb_parking_zone_manager
//
// Drives parking_zone_manager with directed scenarios and random sensor
// traffic. A per-zone occupancy model (integer counts, remaining gate-open
// cycles) predicts every output after each rising edge.
// Honors PARKING_ERR_FLAG_EN the same way as the design.
// ----------------------------------------------------------------------------
module tb_parking_zone_manager;

    localparam int NZ   = 2;
    localparam int CAP  = 8;
    localparam int CW   = 4;
    localparam int HOLD = 3;

    logic              CLK = 1'b0;
    logic              RESET = 1'b1;
    logic [NZ-1:0]     ENTRY_sensor = '0;
    logic [NZ-1:0]     EXIT_sensor  = '0;
    logic [NZ*CW-1:0]  Parking_count, Available_spots;
    logic [7:0]        Total_count;
    logic [NZ-1:0]     FULL, EMPTY, GATE_open, Reject;
    logic              ALL_FULL, ERR;

    parking_zone_manager #(
        .NUM_ZONES (NZ),
        .ZONE_CAP  (CAP),
        .CNT_W     (CW),
        .GATE_HOLD (HOLD)
    ) dut (
        .CLK             (CLK),
        .RESET           (RESET),
        .ENTRY_sensor    (ENTRY_sensor),
        .EXIT_sensor     (EXIT_sensor),
        .Parking_count   (Parking_count),
        .Available_spots (Available_spots),
        .Total_count     (Total_count),
        .FULL            (FULL),
        .EMPTY           (EMPTY),
        .ALL_FULL        (ALL_FULL),
        .GATE_open       (GATE_open),
        .Reject          (Reject),
        .ERR             (ERR)
    );

    always #5 CLK = ~CLK;

`ifdef PARKING_ERR_FLAG_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    int vectors    = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: occupancy per zone and remaining open cycles per gate.
    int cnt  [NZ];
    int left [NZ];
    bit rej  [NZ];
    bit err_m;
    logic [NZ-1:0] pe, px;

    always @(posedge CLK) begin
        logic [NZ-1:0] en, ex;
        en = ENTRY_sensor;
        ex = EXIT_sensor;
        if (RESET) begin
            for (int z = 0; z < NZ; z++) begin
                cnt[z] = 0; left[z] = 0; rej[z] = 0;
            end
            err_m = 0; pe = '0; px = '0;
        end else begin
            for (int z = 0; z < NZ; z++) begin
                bit e, x, g;
                e = en[z] && !pe[z];
                x = ex[z] && !px[z];
                g = 0;
                rej[z] = 0;
                if (e && x) g = 1;
                else if (e) begin
                    if (cnt[z] == CAP) begin rej[z] = 1; err_m = 1; end
                    else begin cnt[z]++; g = 1; end
                end else if (x) begin
                    if (cnt[z] == 0) err_m = 1;
                    else cnt[z]--;
                end
                if (g) left[z] = HOLD;
                else if (left[z] > 0) left[z]--;
            end
            pe = en; px = ex;
        end
        #1;
        begin
            logic [NZ*CW-1:0] e_cnt, e_av;
            logic [NZ-1:0] e_full, e_empty, e_gate, e_rej;
            int tot;
            tot = 0;
            for (int z = 0; z < NZ; z++) begin
                e_cnt[z*CW +: CW] = CW'(cnt[z]);
                e_av[z*CW +: CW]  = CW'(CAP - cnt[z]);
                e_full[z]  = (cnt[z] == CAP);
                e_empty[z] = (cnt[z] == 0);
                e_gate[z]  = (left[z] > 0);
                e_rej[z]   = rej[z];
                tot += cnt[z];
            end
            chk("count",    32'(Parking_count),   32'(e_cnt));
            chk("avail",    32'(Available_spots), 32'(e_av));
            chk("total",    32'(Total_count),     32'(tot));
            chk("full",     32'(FULL),            32'(e_full));
            chk("empty",    32'(EMPTY),           32'(e_empty));
            chk("all_full", 32'(ALL_FULL),        32'(&e_full));
            chk("gate",     32'(GATE_open),       32'(e_gate));
            chk("reject",   32'(Reject),          32'(e_rej));
            chk("err",      32'(ERR),             32'(err_m & ERR_EN));
        end
    end

    // Apply one cycle of inputs; returns once that edge's outputs have settled.
    task automatic drive(input logic [NZ-1:0] e, input logic [NZ-1:0] x, input logic r);
        @(negedge CLK);
        ENTRY_sensor = e;
        EXIT_sensor  = x;
        RESET        = r;
        @(posedge CLK);
        #2;
    endtask

    task automatic pulse(input logic [NZ-1:0] e, input logic [NZ-1:0] x, input int n);
        for (int i = 0; i < n; i++) begin
            drive(e, x, 1'b0);
            drive('0, '0, 1'b0);
        end
    endtask

    function automatic logic [NZ-1:0] rbits(input int pct);
        logic [NZ-1:0] b;
        for (int z = 0; z < NZ; z++) b[z] = ($urandom_range(0, 99) < pct);
        return b;
    endfunction

    initial begin
        drive('0, '0, 1'b1);
        drive('0, '0, 1'b1);
        chk("lit_rst_count", 32'(Parking_count),   32'h00);
        chk("lit_rst_avail", 32'(Available_spots), 32'h88);
        chk("lit_rst_empty", 32'(EMPTY),           32'h3);

        // Five entries into zone 0, then watch the gate hold.
        pulse(2'b01, 2'b00, 4);
        drive(2'b01, 2'b00, 1'b0);
        chk("lit_z0_count", 32'(Parking_count),   32'h05);
        chk("lit_z0_avail", 32'(Available_spots), 32'h83);
        chk("lit_z0_total", 32'(Total_count),     32'd5);
        chk("lit_gate_h0",  32'(GATE_open[0]),    32'd1);
        drive('0, '0, 1'b0);
        chk("lit_gate_h1",  32'(GATE_open[0]),    32'd1);
        drive('0, '0, 1'b0);
        chk("lit_gate_h2",  32'(GATE_open[0]),    32'd1);
        drive('0, '0, 1'b0);
        chk("lit_gate_h3",  32'(GATE_open[0]),    32'd0);

        // Nine entries into zone 1: the ninth is refused.
        pulse(2'b10, 2'b00, 8);
        drive(2'b10, 2'b00, 1'b0);
        chk("lit_z1_reject", 32'(Reject),        32'h2);
        chk("lit_z1_count",  32'(Parking_count), 32'h85);
        chk("lit_z1_full",   32'(FULL),          32'h2);
        chk("lit_z1_err",    32'(ERR),           32'(ERR_EN));
        drive('0, '0, 1'b0);
        chk("lit_z1_rej_off", 32'(Reject),       32'h0);

        // Fill zone 0, then simultaneous entry and exit while full.
        pulse(2'b01, 2'b00, 3);
        drive(2'b01, 2'b01, 1'b0);
        chk("lit_sim_count", 32'(Parking_count), 32'h88);
        chk("lit_sim_gate",  32'(GATE_open[0]),  32'd1);
        chk("lit_sim_rej",   32'(Reject),        32'h0);
        chk("lit_allfull",   32'(ALL_FULL),      32'd1);
        chk("lit_total16",   32'(Total_count),   32'd16);

        // Reset while the gate is mid-hold.
        drive('0, '0, 1'b1);
        chk("lit_mr_count", 32'(Parking_count),   32'h00);
        chk("lit_mr_avail", 32'(Available_spots), 32'h88);
        chk("lit_mr_total", 32'(Total_count),     32'd0);
        chk("lit_mr_gate",  32'(GATE_open),       32'h0);
        chk("lit_mr_empty", 32'(EMPTY),           32'h3);
        chk("lit_mr_err",   32'(ERR),             32'd0);

        // Exits on an empty zone must not wrap.
        pulse(2'b00, 2'b10, 3);
        chk("lit_nowrap", 32'(Parking_count), 32'h00);
        chk("lit_empty1", 32'(EMPTY[1]),      32'd1);

        // Sensor held high across reset release counts as an edge.
        drive(2'b01, 2'b00, 1'b1);
        drive(2'b01, 2'b00, 1'b0);
        chk("lit_held_count", 32'(Parking_count), 32'h01);
        drive('0, '0, 1'b0);

        // Random traffic: entry-biased phase, balanced phase, exit-biased phase.
        for (int i = 0; i < 3000; i++) begin
            int pe_pct, px_pct;
            pe_pct = (i < 1000) ? 70 : (i < 2000) ? 50 : 20;
            px_pct = (i < 1000) ? 20 : (i < 2000) ? 50 : 70;
            drive(rbits(pe_pct), rbits(px_pct), ($urandom_range(0, 99) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
